// File: rtl/i2s_transmitter_pkg.sv
// i2s_transmitter_pkg: shared I2S parameter defaults and state type.
package i2s_transmitter_pkg;
  localparam int NUMBER_OF_BITS_DEF = 16;
  localparam int SLOT_BITS_DEF = 32;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/i2s_sample_holder.sv
// i2s_sample_holder: one-entry stereo holding register with valid/ready handshake.
module i2s_sample_holder #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid,
  input  logic         take,
  input  logic [W-1:0] left_in,
  input  logic [W-1:0] right_in,
  output logic         ready,
  output logic         full,
  output logic [W-1:0] left_out,
  output logic [W-1:0] right_out
);
  logic full_q, full_d, accept;
  logic [W-1:0] left_q, left_d, right_q, right_d;
  // A take while empty leaves the register free, so a coincident accept still lands here.
  always_comb begin
    accept = valid & ~full_q;
    full_d = accept ? 1'b1 : (take ? 1'b0 : full_q);
    left_d = accept ? left_in : left_q;
    right_d = accept ? right_in : right_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      left_q <= '0;
      right_q <= '0;
    end else begin
      full_q <= full_d;
      left_q <= left_d;
      right_q <= right_d;
    end
  end
  assign ready = ~full_q;
  assign full = full_q;
  assign left_out = left_q;
  assign right_out = right_q;
endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: I2S serializer with frame-aligned enable and underrun tracking.
module i2s_transmitter
  import i2s_transmitter_pkg::*;
#(
  parameter int NUMBER_OF_BITS = NUMBER_OF_BITS_DEF,
  parameter int SLOT_BITS = SLOT_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  input  logic [NUMBER_OF_BITS-1:0] sample_left,
  input  logic [NUMBER_OF_BITS-1:0] sample_right,
  output logic                      ws_out,
  output logic                      sd_out,
  output logic                      frame_start,
  output logic                      underrun,
  output logic [7:0]                underrun_count
);
  localparam int CW = $clog2(2 * SLOT_BITS);
  localparam logic [CW-1:0] LAST = CW'(2 * SLOT_BITS - 1);
  localparam logic [CW-1:0] SLOT = CW'(SLOT_BITS);
  localparam logic [CW-1:0] L_END = CW'(NUMBER_OF_BITS);
  localparam logic [CW-1:0] R_BEG = CW'(SLOT_BITS + 1);
  localparam logic [CW-1:0] R_END = CW'(SLOT_BITS + NUMBER_OF_BITS);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUMBER_OF_BITS-1:0] left_q, left_d, right_q, right_d, held_l, held_r;
  logic urun_q, urun_d, fb, wrap, in_l, in_r, full;
  logic [7:0] ucnt_q, ucnt_d;
  i2s_sample_holder #(.W(NUMBER_OF_BITS)) u_holder (
    .clk(clk),
    .reset(reset),
    .valid(sample_valid),
    .take(fb),
    .left_in(sample_left),
    .right_in(sample_right),
    .ready(sample_ready),
    .full(full),
    .left_out(held_l),
    .right_out(held_r)
  );
  // Data bits sit one clock after each ws edge; shift registers present their MSB on sd_out.
  always_comb begin
    wrap = state_q == RUN && cnt_q == LAST;
    fb = enable && (state_q == IDLE || wrap);
    in_l = state_q == RUN && cnt_q != '0 && cnt_q <= L_END;
    in_r = state_q == RUN && cnt_q >= R_BEG && cnt_q <= R_END;
    state_d = fb ? RUN : (wrap ? IDLE : state_q);
    cnt_d = (fb || wrap) ? '0 : (state_q == RUN ? cnt_q + 1'b1 : cnt_q);
    left_d = fb ? (full ? held_l : '0) : (in_l ? left_q << 1 : left_q);
    right_d = fb ? (full ? held_r : '0) : (in_r ? right_q << 1 : right_q);
    urun_d = fb ? ~full : urun_q;
    ucnt_d = (fb && !full && ucnt_q != 8'hFF) ? ucnt_q + 8'd1 : ucnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      left_q <= '0;
      right_q <= '0;
      urun_q <= 1'b0;
      ucnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      left_q <= left_d;
      right_q <= right_d;
      urun_q <= urun_d;
      ucnt_q <= ucnt_d;
    end
  end
  always_comb begin
    ws_out = state_q == RUN && cnt_q >= SLOT;
    sd_out = in_l ? left_q[NUMBER_OF_BITS-1] : (in_r ? right_q[NUMBER_OF_BITS-1] : 1'b0);
    frame_start = state_q == RUN && cnt_q == '0;
    underrun = frame_start && urun_q;
    underrun_count = ucnt_q;
  end
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: frame-level reference model checked every cycle plus directed scenarios.
module tb_i2s_transmitter;
  localparam int N = 16, S = 32, F = 2 * S;
  logic clk = 1'b0;
  logic reset, enable, sample_valid, sample_ready, ws_out, sd_out, frame_start, underrun;
  logic [N-1:0] sample_left, sample_right;
  logic [7:0] underrun_count;
  int checks = 0, errors = 0;
  bit m_run, m_urun;
  int m_pos, m_ucnt;
  logic [N-1:0] m_l, m_r;
  logic [2*N-1:0] m_hold[$];

  i2s_transmitter dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample_left(sample_left),
    .sample_right(sample_right),
    .ws_out(ws_out),
    .sd_out(sd_out),
    .frame_start(frame_start),
    .underrun(underrun),
    .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_sd();
    if (!m_run) return 1'b0;
    if (m_pos >= 1 && m_pos <= N) return m_l[N-m_pos];
    if (m_pos >= S + 1 && m_pos <= S + N) return m_r[S+N-m_pos];
    return 1'b0;
  endfunction

  task automatic cyc(input bit rs, input bit en, input bit v, input logic [N-1:0] l, input logic [N-1:0] r);
    bit acc;
    reset = rs; enable = en; sample_valid = v; sample_left = l; sample_right = r;
    acc = v && m_hold.size() == 0;
    @(posedge clk);
    if (rs) begin
      m_run = 0; m_pos = 0; m_hold.delete(); m_l = '0; m_r = '0; m_urun = 0; m_ucnt = 0;
    end else begin
      if (en && (!m_run || m_pos == F - 1)) begin
        if (m_hold.size() != 0) begin
          {m_l, m_r} = m_hold.pop_front();
          m_urun = 0;
        end else begin
          m_l = '0; m_r = '0; m_urun = 1;
          if (m_ucnt < 255) m_ucnt++;
        end
        m_run = 1; m_pos = 0;
      end else if (m_run) begin
        if (m_pos == F - 1) begin m_run = 0; m_pos = 0; end
        else m_pos++;
      end
      if (acc) m_hold.push_back({l, r});
    end
    #1;
    chk("ready", sample_ready, m_hold.size() == 0);
    chk("ws", ws_out, m_run && m_pos >= S);
    chk("sd", sd_out, exp_sd());
    chk("frame_start", frame_start, m_run && m_pos == 0);
    chk("underrun", underrun, m_run && m_pos == 0 && m_urun);
    chk("underrun_count", underrun_count, m_ucnt);
  endtask

  initial begin
    logic [N-1:0] cap_l, cap_r;
    int ws_rise, ws_fall, n_urun;
    // reset state
    repeat (3) cyc(1, 0, 0, '0, '0);
    chk("rst_ready", sample_ready, 1'b1);
    chk("rst_ws", ws_out, 1'b0);
    // single known pair, first frame decoded bit by bit
    cyc(0, 0, 1, 16'hA5F0, 16'h0F0F);
    chk("loaded_not_ready", sample_ready, 1'b0);
    cap_l = '0; cap_r = '0; ws_rise = -1; ws_fall = -1;
    for (int k = 0; k < F; k++) begin
      cyc(0, 1, 0, '0, '0);
      if (m_pos >= 1 && m_pos <= N) cap_l = {cap_l[N-2:0], sd_out};
      if (m_pos >= S + 1 && m_pos <= S + N) cap_r = {cap_r[N-2:0], sd_out};
      if (ws_out && ws_rise < 0) ws_rise = m_pos;
    end
    cyc(0, 1, 0, '0, '0);
    if (!ws_out) ws_fall = m_pos;
    chk("frame_left", cap_l, 16'hA5F0);
    chk("frame_right", cap_r, 16'h0F0F);
    chk("ws_rise_pos", ws_rise, S);
    chk("ws_fall_pos", ws_fall, 0);
    // drop enable at cnt 40: frame completes, then idle
    for (int k = 0; k < F && m_pos != 40; k++) cyc(0, 1, 0, '0, '0);
    chk("reached_40", m_pos, 40);
    for (int k = 0; k < 40; k++) cyc(0, 0, 0, '0, '0);
    chk("idle_ws", ws_out, 1'b0);
    chk("idle_sd", sd_out, 1'b0);
    // back-to-back pairs with valid held high
    cyc(0, 0, 1, N'($urandom), N'($urandom));
    n_urun = 0;
    for (int k = 0; k < 6 * F; k++) begin
      cyc(0, 1, 1, N'($urandom), N'($urandom));
      if (underrun) n_urun++;
    end
    chk("b2b_no_underrun", n_urun, 0);
    for (int k = 0; k < 3 * F; k++) cyc(0, k < 2 * F, 0, '0, '0);
    // accept coincident with frame boundary while empty
    chk("coinc_idle_empty", sample_ready, 1'b1);
    cyc(0, 1, 1, 16'h1234, 16'h5678);
    chk("coinc_underrun", underrun, 1'b1);
    for (int k = 0; k < F - 1; k++) cyc(0, 1, 0, '0, '0);
    cap_l = '0;
    for (int k = 0; k < F; k++) begin
      cyc(0, 1, 0, '0, '0);
      if (m_pos >= 1 && m_pos <= N) cap_l = {cap_l[N-2:0], sd_out};
    end
    chk("coinc_next_left", cap_l, 16'h1234);
    // randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
          N'($urandom), N'($urandom));
    // reset mid-frame with holding full
    cyc(1, 0, 0, '0, '0);
    cyc(0, 0, 1, 16'hCAFE, 16'hBEEF);
    for (int k = 0; k < 10; k++) cyc(0, 1, 0, '0, '0);
    cyc(0, 1, 1, 16'hDEAD, 16'hF00D);
    for (int k = 0; k < F && m_pos != 20; k++) cyc(0, 1, 0, '0, '0);
    chk("rst_mid_full", sample_ready, 1'b0);
    cyc(1, 1, 0, '0, '0);
    chk("rst_mid_ready", sample_ready, 1'b1);
    chk("rst_mid_sd", sd_out, 1'b0);
    for (int k = 0; k < 2 * F; k++) cyc(0, 1, 0, '0, '0);
    // starvation: saturating underrun count
    cyc(1, 0, 0, '0, '0);
    for (int k = 0; k < 300 * F; k++) cyc(0, 1, 0, '0, '0);
    chk("urun_saturated", underrun_count, 8'd255);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2s_transmitter.md
I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 Parameter NUMBER_OF_BITS, default 16, sample width per channel.
REQ-002 Parameter SLOT_BITS, default 32, clocks per ws half-period; SHALL satisfy SLOT_BITS >= NUMBER_OF_BITS+1.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  run request; sampled only at frame boundaries and in IDLE.
REQ-006 sample_valid  in  1  producer offers a stereo pair.
REQ-007 sample_ready  out  1  holding register empty; transfer when valid&ready at a rising edge.
REQ-008 sample_left  in  NUMBER_OF_BITS  left sample, two's complement.
REQ-009 sample_right  in  NUMBER_OF_BITS  right sample, two's complement.
REQ-010 ws_out  out  1  word select; 0 = left slot, 1 = right slot.
REQ-011 sd_out  out  1  serial data, MSB first.
REQ-012 frame_start  out  1  one-cycle pulse during frame count 0.
REQ-013 underrun  out  1  one-cycle pulse during count 0 of a frame sent without fresh data.
REQ-014 underrun_count  out  8  saturating count of underrun frames.

Function
REQ-015 State machine SHALL have two states: IDLE and RUN.
REQ-016 Frame counter cnt SHALL count 0..2*SLOT_BITS-1 in RUN and wrap to 0.
REQ-017 Frame boundary event fb: (IDLE and enable) or (RUN, cnt = 2*SLOT_BITS-1, enable); at fb the next state is RUN and cnt <= 0.
REQ-018 RUN with cnt = 2*SLOT_BITS-1 and enable low SHALL go to IDLE; disable never truncates a frame.
REQ-019 ws_out SHALL be 1 when RUN and cnt >= SLOT_BITS, otherwise 0.
REQ-020 sd_out SHALL carry left bit NUMBER_OF_BITS-k at cnt = k (k = 1..NUMBER_OF_BITS), and right bit NUMBER_OF_BITS-k at cnt = SLOT_BITS+k (I2S one-bit delay).
REQ-021 sd_out SHALL be 0 at all other cnt values and in IDLE.
REQ-022 ws_out, sd_out, frame_start and underrun SHALL be decoded from registered state only, with no combinational path from any input.
REQ-023 One-entry holding register; sample_ready = not holding_full.
REQ-024 At fb with holding full: move the pair into the shift registers and clear holding_full at the same edge.
REQ-025 At fb with holding empty: load zeros, pulse underrun during the new count 0, and increment underrun_count, saturating at 255.
REQ-026 Simultaneous accept and fb with holding empty: the accepted pair enters holding, the current frame is an underrun, and the pair is sent in the next frame.
REQ-027 The producer may hold valid high; inputs SHALL be ignored when sample_ready is low.
REQ-028 A pair sent is never altered mid-frame by new handshakes.

Reset
REQ-029 On reset: state=IDLE, cnt=0, holding empty, shift registers=0, underrun_count=0.
REQ-030 During and after reset: ws_out=0, sd_out=0, frame_start=0, underrun=0, sample_ready=1.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately and discard held data.

Structure
REQ-032 NUMBER_OF_BITS and SLOT_BITS defaults SHALL live in the shared parameters include used by the I2S receive path.
REQ-033 Counter widths SHALL derive from $clog2(2*SLOT_BITS).
REQ-034 One sub-module is natural: i2s_sample_holder (holding register plus valid/ready); all other logic is flat.

Verification
REQ-035 Load left=16'hA5F0, right=16'h0F0F, then enable -> sd_out bits at cnt 1..16 = A5F0 MSB first, at cnt 33..48 = 0F0F; 0 elsewhere; ws_out toggles at cnt 32 and 0.
REQ-036 Back-to-back pairs with valid held high -> ready drops after accept and rises the cycle after each fb; no frame skipped; underrun never pulses.
REQ-037 Enable with no data -> zero frames; underrun pulses each frame; count reaches 255 after 300 frames and holds.
REQ-038 valid&ready coincident with fb while empty -> that frame is zero (underrun), next frame carries the pair.
REQ-039 Drop enable at cnt 40 -> frame completes to cnt 63, then IDLE with ws_out=0 and sd_out=0.
REQ-040 Assert reset at cnt 20 with holding full -> next cycle all outputs at reset values, ready=1, and the held pair is never transmitted.
